// File: rtl/muldiv_iter_pkg.sv
// rtl/muldiv_iter_pkg.sv - op encodings, FSM states, handshake levels and op decode for muldiv_iter
package muldiv_iter_pkg;

   localparam logic [2:0] MD_MULTU = 3'b000;
   localparam logic [2:0] MD_MULT  = 3'b001;
   localparam logic [2:0] MD_DIVU  = 3'b010;
   localparam logic [2:0] MD_DIV   = 3'b011;
   localparam logic [2:0] MD_MADDU = 3'b100;
   localparam logic [2:0] MD_MADD  = 3'b101;
   localparam logic [2:0] MD_MSUBU = 3'b110;
   localparam logic [2:0] MD_MSUB  = 3'b111;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BUSY   = 2'd1;
   localparam logic [1:0] ST_DZERO  = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   typedef struct packed {
      logic is_div;
      logic is_signed;
      logic is_acc;
      logic is_sub;
   } md_dec_t;

   function automatic md_dec_t md_decode(input logic [2:0] op);
      md_dec_t d;
      d = '0;
      case (op)
         MD_MULTU: ;
         MD_MULT:  d.is_signed = 1'b1;
         MD_DIVU:  d.is_div = 1'b1;
         MD_DIV:   begin d.is_div = 1'b1; d.is_signed = 1'b1; end
         MD_MADDU: d.is_acc = 1'b1;
         MD_MADD:  begin d.is_acc = 1'b1; d.is_signed = 1'b1; end
         MD_MSUBU: begin d.is_acc = 1'b1; d.is_sub = 1'b1; end
         MD_MSUB:  begin d.is_acc = 1'b1; d.is_sub = 1'b1; d.is_signed = 1'b1; end
         default:  ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// rtl/muldiv_iter_if.sv - request/result bundle between the EX stage and muldiv_iter
interface muldiv_iter_if #(
   parameter int WIDTH = 32
);
   logic               start_i;
   logic               annul_i;
   logic [2:0]         op_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic [2*WIDTH-1:0] acc_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;
   logic               busy_o;
   logic               div_zero_o;

   modport master (
      output start_i, annul_i, op_i, opdata1_i, opdata2_i, acc_i,
      input  result_o, ready_o, busy_o, div_zero_o
   );

   modport slave (
      input  start_i, annul_i, op_i, opdata1_i, opdata2_i, acc_i,
      output result_o, ready_o, busy_o, div_zero_o
   );
endinterface

// File: rtl/muldiv_abs.sv
// rtl/muldiv_abs.sv - conditional two's-complement negate, used for magnitudes and sign fix
module muldiv_abs #(
   parameter int WIDTH = 32
) (
   input  logic             neg_i,
   input  logic [WIDTH-1:0] a_i,
   output logic [WIDTH-1:0] y_o
);
   assign y_o = neg_i ? (~a_i + WIDTH'(1)) : a_i;
endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - radix-2 iterative signed/unsigned multiply, divide, multiply-accumulate
// One engine register is shared: shift-add for products, restoring shift-subtract for quotients.
module muldiv_iter
   import muldiv_iter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic          clk,
   input logic          rst,
   muldiv_iter_if.slave bus
);
   localparam int W2 = 2 * WIDTH;

   logic [1:0]       state_q, state_d;
   md_dec_t          dec_q, dec_d;
   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W2:0]      wq_q, wq_d;
   logic [W2-1:0]    result_q, result_d;
   logic             div_zero_q, div_zero_d;

   md_dec_t          in_dec;
   logic             in_neg1, in_neg2;
   logic [WIDTH-1:0] mag1, mag2;

   assign in_dec  = md_decode(bus.op_i);
   assign in_neg1 = in_dec.is_signed & bus.opdata1_i[WIDTH-1];
   assign in_neg2 = in_dec.is_signed & bus.opdata2_i[WIDTH-1];

   muldiv_abs #(.WIDTH(WIDTH)) u_abs_op1 (.neg_i(in_neg1), .a_i(bus.opdata1_i), .y_o(mag1));
   muldiv_abs #(.WIDTH(WIDTH)) u_abs_op2 (.neg_i(in_neg2), .a_i(bus.opdata2_i), .y_o(mag2));

   // Multiply: wq = {partial_hi(W+1), multiplier/product_lo(W)}
   logic [WIDTH:0]   mul_sum;
   logic [W2:0]      mul_next;
   // Divide: wq = {0, rem(W), quot(W)}; opnd_q holds the divisor magnitude
   logic [W2:0]      div_sh;
   logic [WIDTH:0]   div_diff;
   logic [W2:0]      div_next;
   logic [W2:0]      step_next;

   assign mul_sum  = wq_q[W2:WIDTH] + (wq_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {1'b0, mul_sum, wq_q[WIDTH-1:1]};
   assign div_sh   = {wq_q[W2-1:0], 1'b0};
   assign div_diff = div_sh[W2:WIDTH] - {1'b0, opnd_q};
   assign div_next = div_diff[WIDTH] ? div_sh : {div_diff, div_sh[WIDTH-1:1], 1'b1};
   assign step_next = dec_q.is_div ? div_next : mul_next;

   logic             neg_res, neg_rem;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quot_fix, rem_fix;
   logic [W2-1:0]    final_res;

   assign neg_res = dec_q.is_signed & (s1_q ^ s2_q);
   assign neg_rem = dec_q.is_signed & s1_q;

   muldiv_abs #(.WIDTH(W2))    u_fix_prod (.neg_i(neg_res), .a_i(step_next[W2-1:0]),     .y_o(prod_fix));
   muldiv_abs #(.WIDTH(WIDTH)) u_fix_quot (.neg_i(neg_res), .a_i(step_next[WIDTH-1:0]),  .y_o(quot_fix));
   muldiv_abs #(.WIDTH(WIDTH)) u_fix_rem  (.neg_i(neg_rem), .a_i(step_next[W2-1:WIDTH]), .y_o(rem_fix));

   always_comb begin
      final_res = prod_fix;
      if (dec_q.is_div) begin
         final_res = {rem_fix, quot_fix};
      end else if (dec_q.is_acc) begin
         final_res = dec_q.is_sub ? (acc_q - prod_fix) : (acc_q + prod_fix);
      end
   end

   always_comb begin
      state_d    = state_q;
      dec_d      = dec_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      opnd_d     = opnd_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      wq_d       = wq_q;
      result_d   = result_q;
      div_zero_d = div_zero_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start_i == DivStart && !bus.annul_i) begin
               dec_d  = in_dec;
               s1_d   = in_neg1;
               s2_d   = in_neg2;
               acc_d  = bus.acc_i;
               cnt_d  = '0;
               opnd_d = in_dec.is_div ? mag2 : mag1;
               wq_d   = {{(WIDTH+1){1'b0}}, (in_dec.is_div ? mag1 : mag2)};
               if (in_dec.is_div) begin
                  div_zero_d = (bus.opdata2_i == '0);
               end
               if (in_dec.is_div && bus.opdata2_i == '0) begin
                  // Raw dividend, not its magnitude, is returned as the remainder
                  wq_d    = {{(WIDTH+1){1'b0}}, bus.opdata1_i};
                  state_d = ST_DZERO;
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            wq_d  = step_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               result_d = final_res;
               state_d  = ST_FINISH;
            end
         end
         ST_DZERO: begin
            result_d = {wq_q[WIDTH-1:0], {WIDTH{1'b1}}};
            state_d  = ST_FINISH;
         end
         ST_FINISH: begin
            if (bus.start_i == DivStop) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (bus.annul_i) begin
         state_d    = ST_IDLE;
         result_d   = result_q;
         div_zero_d = div_zero_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         dec_q      <= '0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         opnd_q     <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         wq_q       <= '0;
         result_q   <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dec_q      <= dec_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         opnd_q     <= opnd_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         wq_q       <= wq_d;
         result_q   <= result_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.ready_o    = (state_q == ST_FINISH) ? DivResultReady : DivResultNotReady;
   assign bus.busy_o     = (state_q == ST_BUSY);
   assign bus.result_o   = result_q;
   assign bus.div_zero_o = div_zero_q;

endmodule
